// File: rtl/mover_fifo.sv
// Elastic valid/ready word buffer with occupancy count and synchronous flush.
// Define MOVER_STATS_EN to add a saturating pop counter on xfer_count.
module mover_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic             A_valid,
    output logic             A_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    input  logic             flush,
    output logic [CW-1:0]    count
`ifdef MOVER_STATS_EN
    ,
    output logic [31:0]      xfer_count
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Flags come only from registered occupancy, so ready never depends on Y_ready.
    assign A_ready = (count_q != CW'(DEPTH));
    assign Y_valid = (count_q != '0);
    assign Y       = Y_valid ? mem[rd_ptr_q] : '0;
    assign count   = count_q;

    always_comb begin
        push     = A_valid && A_ready && !flush;
        pop      = Y_valid && Y_ready && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= A;
    end

`ifdef MOVER_STATS_EN
    logic [31:0] xfer_count_q, xfer_count_d;

    assign xfer_count = xfer_count_q;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (flush) begin
            xfer_count_d = '0;
        end else if (pop && (xfer_count_q != 32'hFFFF_FFFF)) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) xfer_count_q <= '0;
        else     xfer_count_q <= xfer_count_d;
    end
`endif

endmodule

// File: tb/tb_mover_fifo.sv
// Randomised and directed checks of mover_fifo against a queue model.
// Define MOVER_STATS_EN to also exercise xfer_count.
module tb_mover_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] A = '0;
    logic             A_valid = 1'b0;
    logic             A_ready;
    logic [WIDTH-1:0] Y;
    logic             Y_valid;
    logic             Y_ready = 1'b0;
    logic             flush = 1'b0;
    logic [CW-1:0]    count;
`ifdef MOVER_STATS_EN
    logic [31:0]      xfer_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];
    logic [31:0]      xfer_exp = '0;
    bit               last_push;

    always #5 clk = ~clk;

    mover_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .A(A),
        .A_valid(A_valid),
        .A_ready(A_ready),
        .Y(Y),
        .Y_valid(Y_valid),
        .Y_ready(Y_ready),
        .flush(flush),
        .count(count)
`ifdef MOVER_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    // Advance one clock and apply the handshake rules to the model queue.
    task automatic step();
        bit push, pop;
        logic [WIDTH-1:0] a_in;
        push = A_valid && !flush && (q.size() != DEPTH);
        pop  = Y_ready && !flush && (q.size() != 0);
        a_in = A;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            xfer_exp = '0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                if (xfer_exp != 32'hFFFF_FFFF) xfer_exp = xfer_exp + 1;
            end
            if (push) q.push_back(a_in);
        end
        last_push = push && !flush;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (count !== '0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", count);
        end
        total++;
        if (Y_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_yvalid got=%b want=0", Y_valid);
        end
        total++;
        if (Y !== 8'h00) begin
            bad++;
            $display("FAIL reset_y got=%h want=00", Y);
        end
        rst = 1'b0;
        #1;
        total++;
        if (A_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_aready got=%b want=1", A_ready);
        end
        step();
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp_seq [5];
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        Y_ready = 1'b0;
        A_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = exp_seq[i];
            step();
        end
        total++;
        if (count !== CW'(4)) begin
            bad++;
            $display("FAIL full_count got=%0d want=4", count);
        end
        total++;
        if (A_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_aready got=%b want=0", A_ready);
        end
        A = 8'h55;
        step();
        total++;
        if (count !== CW'(4)) begin
            bad++;
            $display("FAIL full_hold got=%0d want=4", count);
        end
        Y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (Y_valid !== 1'b1 || Y !== exp_seq[i]) begin
                bad++;
                $display("FAIL drain_%0d got=%h/%b want=%h/1",
                         i, Y, Y_valid, exp_seq[i]);
            end
            step();
            if (last_push) A_valid = 1'b0;
            if (i == 0) begin
                total++;
                if (A_ready !== 1'b1 || count !== CW'(3)) begin
                    bad++;
                    $display("FAIL bubble got=%b/%0d want=1/3", A_ready, count);
                end
            end
            if (i == 1) begin
                total++;
                if (count !== CW'(3)) begin
                    bad++;
                    $display("FAIL refill got=%0d want=3", count);
                end
            end
        end
        total++;
        if (count !== '0 || Y_valid !== 1'b0) begin
            bad++;
            $display("FAIL drained got=%0d/%b want=0/0", count, Y_valid);
        end
        A_valid = 1'b0;
        Y_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] got[$];
        A_valid = 1'b1;
        Y_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            A = WIDTH'(i);
            if (Y_valid) got.push_back(Y);
            step();
            total++;
            if (count !== CW'(1)) begin
                bad++;
                $display("FAIL stream_count_%0d got=%0d want=1", i, count);
            end
        end
        A_valid = 1'b0;
        for (int k = 0; k < 5 && Y_valid; k++) begin
            got.push_back(Y);
            step();
        end
        total++;
        if (got.size() != 20) begin
            bad++;
            $display("FAIL stream_len got=%0d want=20", got.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++;
                if (got[i] !== WIDTH'(i)) begin
                    bad++;
                    $display("FAIL stream_word_%0d got=%h want=%h",
                             i, got[i], WIDTH'(i));
                end
            end
        end
        Y_ready = 1'b0;
    endtask

    task automatic test_flush();
        Y_ready = 1'b0;
        A_valid = 1'b1;
        A = 8'h01;
        step();
        A = 8'h02;
        step();
        total++;
        if (count !== CW'(2)) begin
            bad++;
            $display("FAIL flush_pre got=%0d want=2", count);
        end
        flush = 1'b1;
        A = 8'hAA;
        #1;
        total++;
        if (A_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_aready got=%b want=1", A_ready);
        end
        step();
        flush = 1'b0;
        A_valid = 1'b0;
        total++;
        if (count !== '0 || Y_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_post got=%0d/%b want=0/0", count, Y_valid);
        end
        Y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (Y_valid !== 1'b0 || Y === 8'hAA) begin
                bad++;
                $display("FAIL flush_leak got=%h/%b want=00/0", Y, Y_valid);
            end
            step();
        end
        Y_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        A_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = WIDTH'(8'hC0 + i);
            step();
        end
        A_valid = 1'b0;
        total++;
        if (count !== CW'(3)) begin
            bad++;
            $display("FAIL arst_pre got=%0d want=3", count);
        end
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        xfer_exp = '0;
        total++;
        if (count !== '0 || Y_valid !== 1'b0 || Y !== '0) begin
            bad++;
            $display("FAIL arst_now got=%0d/%b/%h want=0/0/00",
                     count, Y_valid, Y);
        end
        #2;
        rst = 1'b0;
        A = 8'h5A;
        A_valid = 1'b1;
        step();
        A_valid = 1'b0;
        total++;
        if (Y_valid !== 1'b1 || Y !== 8'h5A) begin
            bad++;
            $display("FAIL arst_push got=%h/%b want=5a/1", Y, Y_valid);
        end
        Y_ready = 1'b1;
        step();
        Y_ready = 1'b0;
    endtask

    task automatic test_random();
        bit pending = 1'b0;
        for (int n = 0; n < 400; n++) begin
            flush   = ($urandom_range(0, 19) == 0);
            Y_ready = $urandom_range(0, 1) == 1;
            if (!pending) begin
                A_valid = $urandom_range(0, 2) != 0;
                A = WIDTH'($urandom);
            end
            #1;
            total++;
            if (int'(count) != q.size() || A_ready !== (q.size() != DEPTH) ||
                Y_valid !== (q.size() != 0) ||
                Y !== ((q.size() != 0) ? q[0] : '0)) begin
                bad++;
                $display("FAIL rand_%0d got=%0d/%b/%b/%h want=%0d",
                         n, count, A_ready, Y_valid, Y, q.size());
            end
`ifdef MOVER_STATS_EN
            total++;
            if (xfer_count !== xfer_exp) begin
                bad++;
                $display("FAIL rand_xfer_%0d got=%0d want=%0d",
                         n, xfer_count, xfer_exp);
            end
`endif
            step();
            pending = A_valid && !last_push;
        end
        flush = 1'b1;
        A_valid = 1'b0;
        step();
        flush = 1'b0;
        Y_ready = 1'b0;
    endtask

`ifdef MOVER_STATS_EN
    task automatic test_stats();
        flush = 1'b1;
        step();
        flush = 1'b0;
        Y_ready = 1'b1;
        A_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            A = WIDTH'(i);
            step();
        end
        A_valid = 1'b0;
        for (int k = 0; k < 8 && q.size() != 0; k++) step();
        total++;
        if (xfer_count !== 32'd6 || xfer_exp != 32'd6) begin
            bad++;
            $display("FAIL stats_six got=%0d want=6", xfer_count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (xfer_count !== 32'd0) begin
            bad++;
            $display("FAIL stats_flush got=%0d want=0", xfer_count);
        end
        Y_ready = 1'b0;
        A_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = WIDTH'(i);
            step();
        end
        A_valid = 1'b0;
        force dut.xfer_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.xfer_count_q;
        xfer_exp = 32'hFFFF_FFFE;
        Y_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        Y_ready = 1'b0;
        total++;
        if (xfer_count !== 32'hFFFF_FFFF || xfer_exp != 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL stats_sat got=%h want=ffffffff", xfer_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
`ifdef MOVER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
